// File: rtl/maxnet_iter_ctrl.sv
// Maxnet iteration controller: holds four activations, runs PLU rounds until at
// most one activation stays positive or the budget is spent, then names a winner.
module maxnet_iter_ctrl #(
   parameter int WIDTH    = 16,
   parameter int MAX_ITER = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a0,
   input  logic [WIDTH-1:0] in_a1,
   input  logic [WIDTH-1:0] in_a2,
   input  logic [WIDTH-1:0] in_a3,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [1:0]       winner,
   output logic [7:0]       iter_cnt,
   output logic [WIDTH-1:0] act0,
   output logic [WIDTH-1:0] act1,
   output logic [WIDTH-1:0] act2,
   output logic [WIDTH-1:0] act3,
   output logic             plu_start,
   input  logic             plu_done,
   input  logic [WIDTH-1:0] plu_res0,
   input  logic [WIDTH-1:0] plu_res1,
   input  logic [WIDTH-1:0] plu_res2,
   input  logic [WIDTH-1:0] plu_res3
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CHECK, S_FIRE, S_WAIT, S_CAPT, S_FIN
   } state_t;

   localparam logic [7:0] ITER_MAX = 8'(MAX_ITER);

   state_t                state_q, state_d;
   logic [3:0][WIDTH-1:0] act_q, act_d;
   logic [7:0]            iter_q, iter_d;
   logic                  found_q, found_d;
   logic [1:0]            win_q, win_d;

   logic [3:0][WIDTH-1:0] in_v, res_v;
   logic [3:0]            pos;
   logic [2:0]            npos;
   logic [1:0]            best;

   assign in_v  = {in_a3, in_a2, in_a1, in_a0};
   assign res_v = {plu_res3, plu_res2, plu_res1, plu_res0};

   function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? '0 : x;
   endfunction

   // Acts are never negative, so the lowest-index maximum also names the sole
   // survivor when one is left and falls back to index 0 when none is.
   always_comb begin
      pos  = '0;
      npos = '0;
      best = '0;
      for (int i = 0; i < 4; i++) begin
         pos[i] = ~act_q[i][WIDTH-1] & (|act_q[i]);
         npos   = npos + {2'b00, pos[i]};
      end
      for (int i = 1; i < 4; i++)
         if ($signed(act_q[i]) > $signed(act_q[best])) best = 2'(i);
   end

   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      iter_d  = iter_q;
      found_d = found_q;
      win_d   = win_q;
      case (state_q)
         S_IDLE: if (start) begin
            state_d = S_LOAD;
            iter_d  = '0;
         end
         S_LOAD: begin
            for (int i = 0; i < 4; i++) act_d[i] = relu(in_v[i]);
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (npos <= 3'd1 || iter_q == ITER_MAX) begin
               state_d = S_FIN;
               found_d = (npos == 3'd1);
               win_d   = best;
            end else begin
               state_d = S_FIRE;
            end
         end
         S_FIRE: begin
            iter_d  = iter_q + 8'd1;
            state_d = S_WAIT;
         end
         S_WAIT: if (plu_done) state_d = S_CAPT;
         S_CAPT: begin
            for (int i = 0; i < 4; i++) act_d[i] = relu(res_v[i]);
            state_d = S_CHECK;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         act_q   <= '0;
         iter_q  <= '0;
         found_q <= 1'b0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         act_q   <= act_d;
         iter_q  <= iter_d;
         found_q <= found_d;
         win_q   <= win_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_FIN);
   assign plu_start = (state_q == S_FIRE);
   assign found     = found_q;
   assign winner    = win_q;
   assign iter_cnt  = iter_q;
   assign act0      = act_q[0];
   assign act1      = act_q[1];
   assign act2      = act_q[2];
   assign act3      = act_q[3];

endmodule
